// File: rtl/mem_rw_seq.sv
// mem_rw_seq: writes an incrementing data pattern into a block of RAM, then
// reads the block back and compares every word against the pattern. It
// reports the mismatch count, the first failing address and a pass flag.
module mem_rw_seq #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] seed,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] douta,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);
    localparam logic [1:0]      DRAIN_LAST = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [1:0]        drain_q, drain_d;
    logic              wea_q, wea_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [DATA_W-1:0] dina_q, dina_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    // Compare pipeline: one stage per cycle of RAM read latency. Stage 0 is
    // loaded at the edge where the RAM samples the read address.
    logic [RD_LAT-1:0]             pv_q;
    logic [RD_LAT-1:0][DATA_W-1:0] pe_q;
    logic [RD_LAT-1:0][ADDR_W-1:0] pa_q;

    logic [ADDR_W:0]   idx_inc;
    logic [ADDR_W:0]   n_eff;
    logic              last_word;
    logic              mismatch;

    assign idx_inc   = idx_q + ONE;
    assign n_eff     = (len > DEPTH) ? DEPTH : len;
    assign last_word = (idx_q == n_q - ONE);
    assign mismatch  = pv_q[RD_LAT-1] && (douta != pe_q[RD_LAT-1]);

    // Next-state and registered-output decode
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        seed_d     = seed_q;
        n_d        = n_q;
        idx_d      = idx_q;
        drain_d    = drain_q;
        wea_d      = 1'b0;
        addra_d    = addra_q;
        dina_d     = dina_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q + (ADDR_W+1)'(mismatch);
        err_addr_d = (mismatch && (err_cnt_q == '0)) ? pa_q[RD_LAT-1] : err_addr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d     = base_addr;
                    seed_d     = seed;
                    n_d        = n_eff;
                    idx_d      = '0;
                    err_cnt_d  = '0;
                    err_addr_d = '0;
                    pass_d     = 1'b0;
                    if (n_eff != '0) begin
                        state_d = WRITE;
                        wea_d   = 1'b1;
                        addra_d = base_addr;
                        dina_d  = seed;
                        busy_d  = 1'b1;
                    end else begin
                        // Empty run completes immediately with a clean result
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            WRITE: begin
                if (last_word) begin
                    // Read phase starts back at the first address; dina holds
                    state_d = READ;
                    idx_d   = '0;
                    addra_d = base_q;
                end else begin
                    idx_d   = idx_inc;
                    wea_d   = 1'b1;
                    addra_d = base_q + idx_inc[ADDR_W-1:0];
                    dina_d  = seed_q + DATA_W'(idx_inc);
                end
            end
            READ: begin
                if (last_word) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    idx_d   = idx_inc;
                    addra_d = base_q + idx_inc[ADDR_W-1:0];
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    // err_cnt_d already folds in the compare at this edge
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            seed_q     <= '0;
            n_q        <= '0;
            idx_q      <= '0;
            drain_q    <= '0;
            wea_q      <= 1'b0;
            addra_q    <= '0;
            dina_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            seed_q     <= seed_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            drain_q    <= drain_d;
            wea_q      <= wea_d;
            addra_q    <= addra_d;
            dina_q     <= dina_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Pipeline head: captures the read presented during the current cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv_q[0] <= 1'b0;
            pe_q[0] <= '0;
            pa_q[0] <= '0;
        end else begin
            pv_q[0] <= (state_q == READ);
            pe_q[0] <= seed_q + DATA_W'(idx_q);
            pa_q[0] <= addra_q;
        end
    end

    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
            // Delay stage matching one extra cycle of RAM read latency
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    pv_q[gi] <= 1'b0;
                    pe_q[gi] <= '0;
                    pa_q[gi] <= '0;
                end else begin
                    pv_q[gi] <= pv_q[gi-1];
                    pe_q[gi] <= pe_q[gi-1];
                    pa_q[gi] <= pa_q[gi-1];
                end
            end
        end
    endgenerate

    assign wea      = wea_q;
    assign addra    = addra_q;
    assign dina     = dina_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mem_rw_seq.sv
// Testbench for mem_rw_seq: two instances (read latency 1 and 2) share the
// stimulus, each with its own behavioural RAM. Expected writes and run
// results are queued at start acceptance and checked by a monitor.
module tb_mem_rw_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  base_addr;
    logic [6:0]  len;
    logic [31:0] seed;
    logic        fault_en;

    logic [1:0]  wea, busy, done, pass;
    logic [5:0]  addra [2];
    logic [31:0] dina [2];
    logic [31:0] douta [2];
    logic [6:0]  err_cnt [2];
    logic [5:0]  err_addr [2];

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        int unsigned cnt;
        int unsigned eaddr;
        bit          pass;
        int unsigned lat;
        int unsigned c0;
    } res_t;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    res_t res_q [2][$];
    wr_t  wr_q  [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Fault-injecting read view of the RAM
    function automatic logic [31:0] ram_view(input logic [5:0] a, input logic [31:0] d);
        if (fault_en && a == 6'd5) return 32'h0;
        if (fault_en && a == 6'd7) return 32'h1;
        return d;
    endfunction

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic [31:0] mem [64];
            logic [31:0] r1, r2;

            mem_rw_seq #(.ADDR_W(6), .DATA_W(32), .RD_LAT(gi + 1)) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .start    (start),
                .base_addr(base_addr),
                .len      (len),
                .seed     (seed),
                .wea      (wea[gi]),
                .addra    (addra[gi]),
                .dina     (dina[gi]),
                .douta    (douta[gi]),
                .busy     (busy[gi]),
                .done     (done[gi]),
                .pass     (pass[gi]),
                .err_cnt  (err_cnt[gi]),
                .err_addr (err_addr[gi])
            );

            always @(posedge clk) begin
                if (wea[gi]) mem[addra[gi]] <= dina[gi];
                r1 <= ram_view(addra[gi], mem[addra[gi]]);
                r2 <= r1;
            end
            assign douta[gi] = (gi == 0) ? r1 : r2;
        end
    endgenerate

    task automatic check(input string name, input int lane, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s lane=%0d actual=%0h required=%0h", name, lane, act, exp);
        end
    endtask

    // Reference model: expected write stream and run result from the rules
    task automatic push_expect(input int b, input int ln, input logic [31:0] s, input bit f);
        int          n;
        int unsigned cnt;
        int unsigned ea;
        int unsigned a;
        logic [31:0] d, obs;
        res_t        r;
        wr_t         w;
        n   = (ln > 64) ? 64 : ln;
        cnt = 0;
        ea  = 0;
        for (int i = 0; i < n; i++) begin
            a = (b + i) % 64;
            d = s + 32'(i);
            w.addr = a;
            w.data = d;
            for (int l = 0; l < 2; l++) wr_q[l].push_back(w);
            obs = (f && a == 5) ? 32'h0 : (f && a == 7) ? 32'h1 : d;
            if (obs != d) begin
                if (cnt == 0) ea = a;
                cnt++;
            end
        end
        for (int l = 0; l < 2; l++) begin
            r.cnt   = cnt;
            r.eaddr = ea;
            r.pass  = (cnt == 0);
            r.lat   = (n == 0) ? 1 : 2 * n + (l + 1) + 1;
            r.c0    = cyc;
            res_q[l].push_back(r);
        end
    endtask

    // Monitor: pops and compares on every write and every done pulse
    always @(negedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (wea[l]) begin
                check("write_expected", l, 64'(wr_q[l].size() != 0), 64'd1);
                if (wr_q[l].size() != 0) begin
                    wr_t w;
                    w = wr_q[l].pop_front();
                    check("write_addr", l, 64'(addra[l]), 64'(w.addr));
                    check("write_data", l, 64'(dina[l]), 64'(w.data));
                    check("write_busy", l, 64'(busy[l]), 64'd1);
                end
            end
            if (done[l]) begin
                check("done_expected", l, 64'(res_q[l].size() != 0), 64'd1);
                if (res_q[l].size() != 0) begin
                    res_t r;
                    r = res_q[l].pop_front();
                    check("err_cnt", l, 64'(err_cnt[l]), 64'(r.cnt));
                    check("err_addr", l, 64'(err_addr[l]), 64'(r.eaddr));
                    check("pass", l, 64'(pass[l]), 64'(r.pass));
                    check("latency", l, 64'(cyc - r.c0 + 1), 64'(r.lat));
                    check("busy_at_done", l, 64'(busy[l]), 64'd0);
                    $display("lane=%0d done err_cnt=%0d err_addr=%0d pass=%0d latency=%0d",
                             l, err_cnt[l], err_addr[l], pass[l], cyc - r.c0 + 1);
                end
            end
        end
    end

    task automatic check_reset_state();
        for (int l = 0; l < 2; l++) begin
            check("rst_wea", l, 64'(wea[l]), 64'd0);
            check("rst_addra", l, 64'(addra[l]), 64'd0);
            check("rst_dina", l, 64'(dina[l]), 64'd0);
            check("rst_busy", l, 64'(busy[l]), 64'd0);
            check("rst_done", l, 64'(done[l]), 64'd0);
            check("rst_pass", l, 64'(pass[l]), 64'd0);
            check("rst_err_cnt", l, 64'(err_cnt[l]), 64'd0);
            check("rst_err_addr", l, 64'(err_addr[l]), 64'd0);
        end
    endtask

    // Called #1 after the accepting edge: queue expectations, wait out the run
    task automatic accept_and_wait(input int b, input int ln, input logic [31:0] s, input bit f, input bit poke);
        int n;
        start = 1'b0;
        push_expect(b, ln, s, f);
        n = (ln > 64) ? 64 : ln;
        for (int c = 0; c < 2 * n + 6; c++) begin
            @(negedge clk);
            if (poke && n > 0 && c == 2) begin
                start     = 1'b1;
                base_addr = 6'($urandom);
                len       = 7'($urandom_range(1, 40));
                seed      = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        #1;
        for (int l = 0; l < 2; l++) begin
            check("run_complete", l, 64'(res_q[l].size() + wr_q[l].size()), 64'd0);
        end
        $display("run base=%0d len=%0d seed=%0h fault=%0d poke=%0d", b, ln, s, f, poke);
    endtask

    task automatic run(input int b, input int ln, input logic [31:0] s, input bit f, input bit poke);
        @(negedge clk);
        base_addr = 6'(b);
        len       = 7'(ln);
        seed      = s;
        fault_en  = f;
        start     = 1'b1;
        @(posedge clk);
        #1;
        accept_and_wait(b, ln, s, f, poke);
    endtask

    initial begin
        // Reset with start already asserted: must not be taken until release
        rst_n     = 1'b0;
        start     = 1'b1;
        base_addr = 6'd1;
        len       = 7'd8;
        seed      = 32'd3;
        fault_en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        accept_and_wait(1, 8, 32'd3, 1'b0, 1'b0);

        run(62, 4, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run(1, 8, 32'd3, 1'b1, 1'b0);
        run(9, 0, 32'h1234_5678, 1'b0, 1'b0);
        run(17, 100, 32'hDEAD_BEEF, 1'b0, 1'b0);
        run(3, 12, 32'h0000_0100, 1'b0, 1'b1);

        // Reset during the write of word 3
        @(negedge clk);
        base_addr = 6'd40;
        len       = 7'd20;
        seed      = 32'h55;
        fault_en  = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_expect(40, 20, 32'h55, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int l = 0; l < 2; l++) begin
            wr_q[l].delete();
            res_q[l].delete();
            check("abort_wea", l, 64'(wea[l]), 64'd0);
            check("abort_busy", l, 64'(busy[l]), 64'd0);
            check("abort_done", l, 64'(done[l]), 64'd0);
        end
        $display("reset asserted mid-run");
        repeat (2) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++) begin
            run($urandom_range(0, 63), $urandom_range(0, 72), $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            check("final_queues_empty", l, 64'(res_q[l].size() + wr_q[l].size()), 64'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_rw_seq.md
MEM_RW_SEQ -- requirements
Module: mem_rw_seq

Interface
REQ-001 Parameter ADDR_W, default 6, RAM address width (64 words).
REQ-002 Parameter DATA_W, default 32, RAM data width.
REQ-003 Parameter RD_LAT, default 1, RAM read latency in cycles; legal values 1 or 2.
REQ-004 clk  in  1  single clock; all logic rising-edge; same clock as the RAM port.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  run request, sampled in IDLE only.
REQ-007 base_addr  in  ADDR_W  first RAM address of the run, sampled with start.
REQ-008 len  in  ADDR_W+1  word count, sampled with start.
REQ-009 seed  in  DATA_W  data written to the first word, sampled with start.
REQ-010 wea  out  1  RAM write enable.
REQ-011 addra  out  ADDR_W  RAM address.
REQ-012 dina  out  DATA_W  RAM write data.
REQ-013 douta  in  DATA_W  RAM read data.
REQ-014 busy  out  1  high from the cycle after accepted start until done.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 pass  out  1  last run had zero mismatches; held until the next accepted start.
REQ-017 err_cnt  out  ADDR_W+1  mismatch count of the last run.
REQ-018 err_addr  out  ADDR_W  address of the first mismatch of the last run; 0 if none.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 FSM states SHALL be IDLE, WRITE, READ, DRAIN, DONE.
REQ-021 IDLE: start=1 SHALL latch base_addr, seed and effective length N = min(len, 64), clear err_cnt/err_addr, and go to WRITE (N>0) or DONE (N=0).
REQ-022 start while busy SHALL be ignored.
REQ-023 WRITE: for word i = 0..N-1, one per cycle, wea=1, addra=(base_addr+i) mod 2^ADDR_W, dina=(seed+i) mod 2^DATA_W; first write cycle SHALL be the cycle after start was sampled.
REQ-024 After word N-1, READ SHALL follow with no gap: wea=0, addra=(base_addr+i) mod 2^ADDR_W for i = 0..N-1, one per cycle; dina SHALL hold its last value.
REQ-025 A read address driven in cycle t SHALL be compared against douta at the rising edge ending cycle t+RD_LAT, with expected value (seed+i) mod 2^DATA_W; tracking SHALL use an RD_LAT-deep pipeline of {valid, expected, addr}.
REQ-026 Each mismatch SHALL increment err_cnt; the first mismatch of a run SHALL load err_addr; later mismatches SHALL not change err_addr.
REQ-027 DRAIN SHALL last exactly RD_LAT cycles after the last read address so that all compares complete, then go to DONE.
REQ-028 DONE SHALL last one cycle: done=1, busy=0, pass=(err_cnt==0 including the final compare); next state IDLE.
REQ-029 Address wrap from 63 to 0 within a run SHALL be legal; data wrap modulo 2^DATA_W SHALL be legal.
REQ-030 Run length in cycles from start sample to done pulse SHALL be 2N+RD_LAT+1 for N>0, and 1 for N=0 (pass=1, err_cnt=0, no RAM writes).
REQ-031 In IDLE and DONE, wea SHALL be 0.

Reset
REQ-032 With rst_n=0 at a rising edge: state=IDLE, wea=0, addra=0, dina=0, busy=0, done=0, pass=0, err_cnt=0, err_addr=0, compare pipeline cleared.
REQ-033 Reset mid-run SHALL abort with no further RAM write after that edge and no done pulse; partial RAM contents are not restored.
REQ-034 start held high during reset SHALL not be accepted until the first edge with rst_n=1.

Verification
REQ-035 Basic: base_addr=1, len=8, seed=3 with RD_LAT=1 behavioural RAM -> writes 3..10 to addresses 1..8, reads back, done at cycle 18 after start, pass=1, err_cnt=0.
REQ-036 Wrap: base_addr=62, len=4, seed=32'hFFFF_FFFE -> writes addresses 62,63,0,1 with data FFFF_FFFE, FFFF_FFFF, 0, 1; pass=1.
REQ-037 Fault injection: RAM model forces address 5 to read 32'h0 and address 7 to read 32'h1, base_addr=1, len=8, seed=3 -> err_cnt=2, err_addr=5, pass=0.
REQ-038 Edge lengths: len=0 -> done one cycle after start, no wea; len=100 -> 64 writes, 64 reads, pass=1.
REQ-039 Control: start pulsed again while busy -> ignored, single done; rst_n=0 during WRITE at word 3 -> wea=0 next cycle, busy=0, no done.
REQ-040 Latency: rerun REQ-035 with RD_LAT=2 and a 2-cycle RAM model -> pass=1, done at cycle 19 after start.
